// File: rtl/ras_predictor_pkg.sv
// Shared constants and the call/return classification encoding for the return-address-stack predictor.
`timescale 1ns/1ps
package ras_predictor_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [2:0] F3_JALR    = 3'b000;
   localparam logic [4:0] LINK_REG_A = 5'd1;
   localparam logic [4:0] LINK_REG_B = 5'd5;

   typedef enum logic [1:0] {
      RAS_NONE     = 2'd0,
      RAS_PUSH     = 2'd1,
      RAS_POP      = 2'd2,
      RAS_POP_PUSH = 2'd3
   } ras_op_e;

   function automatic logic is_link(input logic [4:0] r);
      return (r == LINK_REG_A) || (r == LINK_REG_B);
   endfunction

endpackage

// File: rtl/ras_predictor_decode.sv
// Combinational call/return classifier: maps an RV32 instruction word to a RAS stack operation.
`timescale 1ns/1ps
module ras_decode
   import ras_predictor_pkg::*;
(
   input  logic [31:0] instruction_i,
   output logic [1:0]  ras_op_o
);

   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [2:0]  w_funct3;
   logic        w_rd_link;
   logic        w_rs1_link;
   ras_op_e     w_op;
   logic        w_unused_imm;

   assign w_opcode     = instruction_i[6:0];
   assign w_rd         = instruction_i[11:7];
   assign w_funct3     = instruction_i[14:12];
   assign w_rs1        = instruction_i[19:15];
   assign w_rd_link    = is_link(w_rd);
   assign w_rs1_link   = is_link(w_rs1);
   // The immediate field never affects classification.
   assign w_unused_imm = ^instruction_i[31:20];

   always_comb begin
      w_op = RAS_NONE;
      if (w_opcode == OPC_JAL) begin
         if (w_rd_link) w_op = RAS_PUSH;
      end else if (w_opcode == OPC_JALR && w_funct3 == F3_JALR) begin
         case ({w_rd_link, w_rs1_link})
            2'b10:   w_op = RAS_PUSH;
            2'b01:   w_op = RAS_POP;
            // Same link register on both sides is a plain call (e.g. jalr ra, 0(ra)).
            2'b11:   w_op = (w_rd == w_rs1) ? RAS_PUSH : RAS_POP_PUSH;
            default: w_op = RAS_NONE;
         endcase
      end
   end

   assign ras_op_o = w_op;

endmodule

// File: rtl/ras_predictor.sv
// Return-address-stack predictor: circular stack, registered return-target prediction.
// Optional pointer/count checkpoint with restore-on-flush is enabled by defining RAS_CHECKPOINT_EN.
`timescale 1ns/1ps
module ras_predictor
   import ras_predictor_pkg::*;
#(
   parameter int ADDRESS_BITS = 32,
   parameter int RAS_DEPTH    = 4
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_i,
   input  logic [ADDRESS_BITS-1:0]      pc_i,
   input  logic [31:0]                  instruction_i,
   input  logic                         stall_i,
   input  logic                         flush_i,
   input  logic                         checkpoint_i,
   output logic                         predict_valid_o,
   output logic [ADDRESS_BITS-1:0]      predict_target_o,
   output logic [$clog2(RAS_DEPTH):0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int PTR_BITS = $clog2(RAS_DEPTH);
   localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS+1)'(RAS_DEPTH);

   logic [ADDRESS_BITS-1:0] r_stack [RAS_DEPTH];
   logic [PTR_BITS-1:0]     r_tos;
   logic [PTR_BITS:0]       r_count;
   logic                    r_pred_valid;
   logic [ADDRESS_BITS-1:0] r_pred_target;

   logic [1:0]              w_dec_op;
   ras_op_e                 w_op;
   logic                    w_accept;
   logic [ADDRESS_BITS-1:0] w_link_addr;
   logic [ADDRESS_BITS-1:0] w_top;
   logic [PTR_BITS-1:0]     w_tos_next;
   logic [PTR_BITS:0]       w_count_next;
   logic                    w_wr_en;
   logic [PTR_BITS-1:0]     w_wr_addr;
   logic                    w_load_target;
   logic                    w_pred_fire;

   ras_decode u_decode (
      .instruction_i (instruction_i),
      .ras_op_o      (w_dec_op)
   );

   assign w_accept    = valid_i & ~stall_i & ~flush_i;
   assign w_op        = w_accept ? ras_op_e'(w_dec_op) : RAS_NONE;
   assign w_link_addr = pc_i + ADDRESS_BITS'(4);
   assign w_top       = r_stack[r_tos];

   always_comb begin
      w_tos_next    = r_tos;
      w_count_next  = r_count;
      w_wr_en       = 1'b0;
      w_wr_addr     = r_tos;
      w_load_target = 1'b0;
      w_pred_fire   = 1'b0;
      case (w_op)
         RAS_PUSH: begin
            // Wraps onto the oldest entry when full; the count saturates.
            w_tos_next   = r_tos + 1'b1;
            w_wr_en      = 1'b1;
            w_wr_addr    = r_tos + 1'b1;
            w_count_next = (r_count == DEPTH_CNT) ? r_count : r_count + 1'b1;
         end
         RAS_POP: begin
            if (r_count != '0) begin
               w_load_target = 1'b1;
               w_pred_fire   = 1'b1;
               w_tos_next    = r_tos - 1'b1;
               w_count_next  = r_count - 1'b1;
            end
         end
         RAS_POP_PUSH: begin
            w_load_target = 1'b1;
            w_pred_fire   = (r_count != '0);
            w_wr_en       = 1'b1;
            w_count_next  = (r_count == '0) ? (PTR_BITS+1)'(1) : r_count;
         end
         default: ;
      endcase
   end

`ifdef RAS_CHECKPOINT_EN
   logic [PTR_BITS-1:0] r_ckpt_tos;
   logic [PTR_BITS:0]   r_ckpt_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ckpt_tos   <= '0;
         r_ckpt_count <= '0;
      end else if (checkpoint_i && !stall_i && !flush_i) begin
         r_ckpt_tos   <= w_tos_next;
         r_ckpt_count <= w_count_next;
      end
   end
`else
   logic w_unused_ckpt;
   assign w_unused_ckpt = checkpoint_i;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tos         <= '0;
         r_count       <= '0;
         r_pred_valid  <= 1'b0;
         r_pred_target <= '0;
      end else if (flush_i) begin
         r_pred_valid <= 1'b0;
`ifdef RAS_CHECKPOINT_EN
         r_tos        <= r_ckpt_tos;
         r_count      <= r_ckpt_count;
`endif
      end else if (!stall_i) begin
         r_tos        <= w_tos_next;
         r_count      <= w_count_next;
         r_pred_valid <= w_pred_fire;
         if (w_load_target) r_pred_target <= w_top;
      end
   end

   // Entry storage carries no reset; contents are meaningless until pushed.
   always_ff @(posedge clk) begin
      if (w_wr_en && !reset) r_stack[w_wr_addr] <= w_link_addr;
   end

   assign predict_valid_o  = r_pred_valid;
   assign predict_target_o = r_pred_target;
   assign count_o          = r_count;
   assign empty_o          = (r_count == '0);
   assign full_o           = (r_count == DEPTH_CNT);

endmodule

// File: doc/ras_predictor.md
Name: ras_predictor

Overview:
- Return-address-stack predictor for the fetch/decode boundary of the RISC-V core.
- Classifies each valid instruction as a call or return using the RISC-V link-register hints (x1/x5). Calls push PC+4; returns pop a predicted target.
- Owns circular stack storage, so it wraps on overflow and never stalls.
- Drives a registered prediction to the fetch redirect logic.

Parameters:
- ADDRESS_BITS, 32, width of PC and predicted target.
- RAS_DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- PTR_BITS, log2(RAS_DEPTH) (localparam), width of the top-of-stack pointer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  1  instruction_i/pc_i are valid this cycle.
- pc_i  input  ADDRESS_BITS  PC of instruction_i.
- instruction_i  input  32  raw RV32 instruction word.
- stall_i  input  1  hold all state and outputs.
- flush_i  input  1  discard the current instruction and the pending prediction.
- checkpoint_i  input  1  snapshot the pointer and count (RAS_CHECKPOINT_EN only; otherwise ignored).
- predict_valid_o  output  1  predict_target_o holds a return prediction.
- predict_target_o  output  ADDRESS_BITS  predicted return address.
- count_o  output  PTR_BITS+1  number of valid entries, 0..RAS_DEPTH.
- empty_o  output  1  count_o == 0.
- full_o  output  1  count_o == RAS_DEPTH.

Behaviour:
- Reset: predict_valid_o=0, predict_target_o=0, count=0, tos pointer=0, empty_o=1, full_o=0. Entry contents are don't-care.
- Decode (combinational) when valid_i=1:
  - Opcode 1101111 is JAL; opcode 1100111 with funct3=000 is JALR.
  - link(r) is true for r==1 or r==5.
  - JAL with link(rd): PUSH.
  - JALR:
    - link(rd) and !link(rs1): PUSH.
    - !link(rd) and link(rs1): POP.
    - link(rd) and link(rs1) and rd!=rs1: POP_PUSH.
    - link(rd) and link(rs1) and rd==rs1: PUSH.
    - Neither register is a link: NONE.
  - Any other opcode: NONE.
- Update at the rising edge, applied only if valid_i=1, stall_i=0 and flush_i=0:
  - PUSH: tos=tos+1 modulo RAS_DEPTH; write pc_i+4 to the new tos; count=min(count+1, RAS_DEPTH). When full, the oldest entry is silently overwritten.
  - POP with count>0: predict_target_o=stack[tos]; predict_valid_o=1; tos=tos-1 modulo RAS_DEPTH; count=count-1.
  - POP with count==0: predict_valid_o=0; tos and count unchanged.
  - POP_PUSH: predict_target_o=stack[tos] and predict_valid_o=(count>0). Then stack[tos]=pc_i+4, tos unchanged, count=max(count,1).
  - NONE: predict_valid_o=0.
- pc_i+4 wraps modulo 2^ADDRESS_BITS.
- Latency: one cycle from the accepted instruction to the prediction. predict_valid_o is a single-cycle pulse per return.
- stall_i=1: no state change; predict_valid_o and predict_target_o hold their values.
- flush_i=1, which has priority over stall_i and valid_i:
  - Next cycle predict_valid_o=0.
  - The instruction in that cycle is ignored.
  - Stack state is unchanged, except as described under Optional Feature.
- Reset asserted mid-sequence: all state returns to reset values at the next edge, regardless of other inputs.
- empty_o and full_o are decoded from the registered count.

Optional Feature:
- Macro: RAS_CHECKPOINT_EN.
- Defined:
  - Adds checkpoint registers ckpt_tos and ckpt_count, both reset to 0.
  - checkpoint_i=1 with stall_i=0 snapshots the post-update tos and count of that cycle.
  - flush_i=1 restores tos and count from the checkpoint. Entry contents are not restored.
  - If checkpoint_i and flush_i are high together, the restore happens and the checkpoint registers keep their old values.
- Undefined: checkpoint_i is unused; flush_i leaves tos and count unchanged.

Decomposition:
- Shared package/header holds:
  - opcode constants OPC_JAL=7'b1101111 and OPC_JALR=7'b1100111;
  - link register indices 1 and 5;
  - the ras_op encoding NONE/PUSH/POP/POP_PUSH (2 bits).
- One sub-module, ras_decode: a combinational classifier taking instruction_i and producing ras_op. The top level holds the pointer, count, storage and output registers.

Test Plan:
- Reset then idle -> empty_o=1, full_o=0, count_o=0, predict_valid_o=0.
- JAL x1 at pc 0x100, then JALR x0,0(x1) -> 1 cycle after the return: predict_valid_o=1, predict_target_o=0x104, count_o back to 0.
- Five calls at pcs 0x10,0x20,0x30,0x40,0x50 with RAS_DEPTH=4, then five returns:
  - After the calls: full_o=1, count_o=4.
  - Return targets: 0x54,0x44,0x34,0x24.
  - Fifth return: predict_valid_o=0.
- After one call at 0x200, JALR x5,0(x1) at 0x300 (POP_PUSH) -> target 0x204, count_o=1; next return predicts 0x304.
- Return issued with stall_i=1 for 3 cycles -> count_o unchanged and no pulse; pulse appears 1 cycle after stall_i drops. A return issued in the same cycle as flush_i -> no pulse, count_o unchanged.
- With RAS_CHECKPOINT_EN: call at 0x0, checkpoint_i, then calls at 0x10 and 0x20, then flush_i -> count_o=1; next return predicts 0x4.
